// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// Stage 1 captures the operation, the ALU evaluates it combinationally, and
// stage 2 holds the result and its flags until the consumer takes them.
// A sticky bit records that an overflowing ADD/SUB result was delivered.
module alu_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             illegal_op,
    input  logic             clear_sticky,
    output logic             ovf_sticky
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_SRL = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;

    // Stage 1: the captured operation
    logic             s1_valid_r;
    logic [4:0]       s1_op_r;
    logic [SHW-1:0]   s1_shamt_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;

    // Stage 2: the result presented to the consumer
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             ne_r;
    logic             lt_r;
    logic             ovf_r;
    logic             ill_r;
    logic             sticky_r;

    // Handshake and ALU combinational signals
    logic             s2_load_s;
    logic             accept_s;
    logic             deliver_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic             lt_s;
    logic             ne_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ne_s;
    logic             alu_lt_s;
    logic             alu_ovf_s;
    logic             alu_ill_s;

    // Stage 2 advances when it is empty or its result is being taken; the
    // ready path from out_ready is deliberately combinational (no skid buffer).
    assign s2_load_s = s1_valid_r && (!out_valid_r || out_ready);
    assign in_ready  = !s1_valid_r || s2_load_s;
    assign accept_s  = in_valid && in_ready;
    assign deliver_s = out_valid_r && out_ready;

    // ALU: evaluate the stage-1 operation and its comparison/overflow flags
    always_comb begin
        sum_s     = s1_a_r + s1_b_r;
        diff_s    = s1_a_r - s1_b_r;
        add_ovf_s = (s1_a_r[WIDTH-1] == s1_b_r[WIDTH-1]) && (sum_s[WIDTH-1] != s1_a_r[WIDTH-1]);
        sub_ovf_s = (s1_a_r[WIDTH-1] != s1_b_r[WIDTH-1]) && (diff_s[WIDTH-1] != s1_a_r[WIDTH-1]);
        // Signed less-than stays correct even when A-B wraps around
        lt_s      = diff_s[WIDTH-1] ^ sub_ovf_s;
        ne_s      = (s1_a_r != s1_b_r);
        alu_res_s = {WIDTH{1'b0}};
        alu_ne_s  = ne_s;
        alu_lt_s  = lt_s;
        alu_ovf_s = 1'b0;
        alu_ill_s = 1'b0;
        case (s1_op_r)
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_ovf_s;
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = sub_ovf_s;
            end
            OP_AND: alu_res_s = s1_a_r & s1_b_r;
            OP_OR:  alu_res_s = s1_a_r | s1_b_r;
            OP_SLL: alu_res_s = s1_a_r << s1_shamt_r;
            OP_SRA: alu_res_s = $unsigned($signed(s1_a_r) >>> s1_shamt_r);
            OP_SRL: alu_res_s = s1_a_r >> s1_shamt_r;
            OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_ne_s  = 1'b0;
                alu_lt_s  = 1'b0;
                alu_ovf_s = 1'b0;
                alu_ill_s = 1'b1;
            end
        endcase
    end

    // Stage 1: capture a new operation on acceptance, empty when it moves on
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 5'b00000;
            s1_shamt_r <= {SHW{1'b0}};
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= ctrl_ALUopcode;
            s1_shamt_r <= ctrl_shiftamt;
            s1_a_r     <= data_operandA;
            s1_b_r     <= data_operandB;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: load the ALU result, hold it steady while stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            ne_r        <= 1'b0;
            lt_r        <= 1'b0;
            ovf_r       <= 1'b0;
            ill_r       <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            result_r    <= alu_res_s;
            ne_r        <= alu_ne_s;
            lt_r        <= alu_lt_s;
            ovf_r       <= alu_ovf_s;
            ill_r       <= alu_ill_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky overflow: a delivered overflow wins over a same-cycle clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky_r <= 1'b0;
        end else if (deliver_s && ovf_r) begin
            sticky_r <= 1'b1;
        end else if (clear_sticky) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    assign out_valid   = out_valid_r;
    assign data_result = result_r;
    assign isNotEqual  = ne_r;
    assign isLessThan  = lt_r;
    assign overflow    = ovf_r;
    assign illegal_op  = ill_r;
    assign ovf_sticky  = sticky_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 32-bit instance for the main plan and an
// 8-bit instance for the narrow overflow/sticky case.
module tb_alu_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        isNotEqual, isLessThan, overflow, illegal_op;
    logic        clear_sticky, ovf_sticky;

    logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready;
    logic [4:0]  w8_op;
    logic [2:0]  w8_shamt;
    logic [7:0]  w8_a, w8_b, w8_result;
    logic        w8_ne, w8_lt, w8_ovf, w8_ill, w8_clear, w8_sticky;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] held;

    always #5 clock = ~clock;

    alu_pipe #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .isNotEqual(isNotEqual),
        .isLessThan(isLessThan), .overflow(overflow), .illegal_op(illegal_op),
        .clear_sticky(clear_sticky), .ovf_sticky(ovf_sticky)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .ctrl_ALUopcode(w8_op), .ctrl_shiftamt(w8_shamt),
        .data_operandA(w8_a), .data_operandB(w8_b),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready),
        .data_result(w8_result), .isNotEqual(w8_ne),
        .isLessThan(w8_lt), .overflow(w8_ovf), .illegal_op(w8_ill),
        .clear_sticky(w8_clear), .ovf_sticky(w8_sticky)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on an idle pipe; returns #1 after the edge where the
    // result first shows, with clear_sticky driven for the delivery cycle.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic clr);
        in_valid = 1'b1; out_ready = 1'b1;
        ctrl_ALUopcode = op; data_operandA = a; data_operandB = b; ctrl_shiftamt = sh;
        @(posedge clock); #1;
        in_valid = 1'b0;
        ctrl_ALUopcode = 5'($urandom); ctrl_shiftamt = 5'($urandom);
        data_operandA = $urandom; data_operandB = $urandom;
        @(posedge clock); #1;
        clear_sticky = clr;
    endtask

    task automatic step();
        @(posedge clock); #1;
        clear_sticky = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [31:0] res,
                             input logic ne, input logic lt, input logic ov, input logic il);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, data_result, res);
        chk({tag, "_ne"}, isNotEqual, ne);
        chk({tag, "_lt"}, isLessThan, lt);
        chk({tag, "_ovf"}, overflow, ov);
        chk({tag, "_ill"}, illegal_op, il);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; clear_sticky = 1'b0;
        ctrl_ALUopcode = 5'd0; ctrl_shiftamt = 5'd0;
        data_operandA = 32'd0; data_operandB = 32'd0;
        w8_in_valid = 1'b0; w8_out_ready = 1'b1; w8_op = 5'd0; w8_shamt = 3'd0;
        w8_a = 8'd0; w8_b = 8'd0; w8_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", data_result, 32'd0);
        chk("rst_flags", {isNotEqual, isLessThan, overflow, illegal_op}, 4'b0000);
        chk("rst_sticky", ovf_sticky, 1'b0);

        // Reset with two overflowing-capable ops in flight
        @(posedge clock); #1;
        out_ready = 1'b0; in_valid = 1'b1; ctrl_ALUopcode = 5'b00000;
        data_operandA = 32'h4000_0000; data_operandB = 32'h4000_0000;
        @(posedge clock); #1;
        data_operandA = 32'd7; data_operandB = 32'd8;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("midrst_full_valid", out_valid, 1'b1);
        chk("midrst_full_ready", in_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_sticky", ovf_sticky, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            chk("midrst_no_stale", out_valid, 1'b0);
        end
        chk("midrst_sticky_after", ovf_sticky, 1'b0);

        // Back-to-back ADD stream, one per cycle
        for (int i = 0; i <= 31; i++) begin
            if (i <= 30) begin
                in_valid = 1'b1; ctrl_ALUopcode = 5'b00000;
                data_operandA = 32'd1 << i; data_operandB = 32'd1 << i;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
            if (i == 0) begin
                chk("stream_first_latency", out_valid, 1'b0);
            end else begin
                chk("stream_valid", out_valid, 1'b1);
                chk("stream_result", data_result, 32'd1 << i);
                chk("stream_ovf", overflow, (i == 31) ? 1'b1 : 1'b0);
            end
        end
        @(posedge clock); #1;
        chk("stream_drained", out_valid, 1'b0);
        chk("stream_sticky", ovf_sticky, 1'b1);

        // SUB / compare / logic / shifts / illegal
        run_op(5'b00001, 32'h8000_0001, 32'h7FFF_FFFF, 5'd0, 1'b0);
        chk_flags("sub_ovf", 32'h0000_0002, 1'b1, 1'b1, 1'b1, 1'b0); step();
        run_op(5'b00001, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0);
        chk_flags("sub_eq", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        run_op(5'b00001, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        chk_flags("sub_pos_neg", 32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b0); step();
        run_op(5'b00111, 32'h8000_0001, 32'h7FFF_FFFF, 5'd0, 1'b0);
        chk_flags("slt", 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0); step();
        run_op(5'b00010, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b0);
        chk_flags("and", 32'hF000_F000, 1'b1, 1'b1, 1'b0, 1'b0); step();
        run_op(5'b00011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b0);
        chk_flags("or", 32'hFFF0_FFF0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        run_op(5'b00100, 32'h0000_0001, 32'h0, 5'd24, 1'b0);
        chk_flags("sll", 32'h0100_0000, 1'b1, 1'b0, 1'b0, 1'b0); step();
        run_op(5'b00101, 32'h8000_0000, 32'h0, 5'd4, 1'b0);
        chk_flags("sra", 32'hF800_0000, 1'b1, 1'b1, 1'b0, 1'b0); step();
        run_op(5'b00110, 32'h8000_0000, 32'h0, 5'd4, 1'b0);
        chk_flags("srl", 32'h0800_0000, 1'b1, 1'b1, 1'b0, 1'b0); step();
        run_op(5'b01010, 32'd5, 32'd3, 5'd0, 1'b0);
        chk_flags("illegal", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        chk("after_single_drain", out_valid, 1'b0);

        // Backpressure: five cycles of offered work against a stalled consumer
        begin
            int accepts;
            int idx;
            accepts = 0; idx = 0;
            out_ready = 1'b0; in_valid = 1'b1; ctrl_ALUopcode = 5'b00000;
            data_operandB = 32'd0;
            for (int c = 0; c < 5; c++) begin
                data_operandA = 32'd10 + 32'(idx);
                if (in_ready) begin
                    accepts++; idx++;
                end
                @(posedge clock); #1;
                if (c == 1) held = data_result;
                if (c >= 2) chk("bp_stable", data_result, held);
            end
            in_valid = 1'b0;
            chk("bp_accepts", accepts, 2);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_first", data_result, 32'd10);
            out_ready = 1'b1;
            @(posedge clock); #1;
            chk("bp_drain2_valid", out_valid, 1'b1);
            chk("bp_drain2", data_result, 32'd11);
            @(posedge clock); #1;
            chk("bp_drain_done", out_valid, 1'b0);
        end

        // Sticky clear behaviour
        clear_sticky = 1'b1; step();
        chk("sticky_cleared", ovf_sticky, 1'b0);
        run_op(5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b1);
        chk("sticky_ovf_flag", overflow, 1'b1);
        step();
        chk("sticky_set_wins", ovf_sticky, 1'b1);
        clear_sticky = 1'b1; step();
        chk("sticky_late_clear", ovf_sticky, 1'b0);

        // Narrow instance: 0x7F + 0x01
        w8_in_valid = 1'b1; w8_op = 5'b00000; w8_a = 8'h7F; w8_b = 8'h01;
        @(posedge clock); #1;
        w8_in_valid = 1'b0; w8_a = 8'hA5; w8_b = 8'h3C;
        @(posedge clock); #1;
        chk("w8_valid", w8_out_valid, 1'b1);
        chk("w8_result", w8_result, 8'h80);
        chk("w8_ovf", w8_ovf, 1'b1);
        w8_clear = 1'b1;
        @(posedge clock); #1;
        w8_clear = 1'b0;
        chk("w8_set_wins", w8_sticky, 1'b1);
        w8_clear = 1'b1;
        @(posedge clock); #1;
        w8_clear = 1'b0;
        chk("w8_late_clear", w8_sticky, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
